cache_sweep_reader: RTL and testbench

CACHE_SWEEP_READER -- requirements
Module: cache_sweep_reader

---
 rtl/cache_sweep_reader.sv | 183 ++++++++++++++++++
 tb/tb_cache_sweep_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_sweep_reader.sv
// cache_sweep_reader: reads `count` consecutive 4-byte words from a cache
// starting at base_addr, keeps at most MAX_OUT reads in flight, and
// accumulates a wrap-around checksum of the returned data.
// Optional feature: define CACHE_SWEEP_RESPCHK_EN to check each response's
// type and opaque tag; a mismatch sets the sticky err flag.

package cache_sweep_reader_pkg;
    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;
endpackage

// state | meaning
// IDLE  | waiting for start; response channel closed
// ISSUE | sending read requests, collecting responses
// DRAIN | all requests sent, collecting remaining responses
// DONE  | one-cycle done pulse, then back to IDLE
module cache_sweep_reader
    import cache_sweep_reader_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  base_addr,
    input  logic [15:0]  count,
    output logic         cachereq_val,
    input  logic         cachereq_rdy,
    output mem_req_4B_t  cachereq_msg,
    input  logic         cacheresp_val,
    output logic         cacheresp_rdy,
    input  mem_resp_4B_t cacheresp_msg,
    output logic         busy,
    output logic         done,
    output logic [31:0]  checksum,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [29:0] r_base_word;
    logic [15:0] r_count;
    logic [15:0] r_issued;
    logic [15:0] r_received;
    logic [31:0] r_checksum;
    logic        r_err;

    logic [15:0] w_outstanding;
    logic        w_start_ok;
    logic        w_issue_ok;
    logic        w_rx_ok;
    logic        w_req_hs;
    logic        w_resp_hs;
    logic        w_unused_resp;

    assign w_outstanding = r_issued - r_received;
    assign w_start_ok    = (r_state == S_IDLE) && start;
    assign w_issue_ok    = (r_state == S_ISSUE) && (r_issued < r_count)
                           && (w_outstanding < 16'(MAX_OUT));
    assign w_rx_ok       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_req_hs      = w_issue_ok && cachereq_rdy;
    assign w_resp_hs     = w_rx_ok && cacheresp_val;

    // The request message is a pure function of registered state, so it
    // cannot change while a request is stalled by backpressure.
    assign cachereq_val  = w_issue_ok;
    assign cachereq_msg  = '{type_:  MEM_READ,
                             opaque: r_issued[7:0],
                             addr:   {r_base_word + 30'(r_issued), 2'b00},
                             len:    2'd0,
                             data:   32'd0};
    assign cacheresp_rdy = w_rx_ok;
    assign checksum      = r_checksum;
    assign err           = r_err;

    assign w_unused_resp = ^{base_addr[1:0], cacheresp_msg.type_,
                             cacheresp_msg.opaque, cacheresp_msg.test,
                             cacheresp_msg.len};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (count != 16'd0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (w_req_hs && (r_issued + 16'd1 == r_count)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_resp_hs && (r_received + 16'd1 == r_count)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sweep parameters, issue/receive counters and checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base_word <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_received  <= '0;
            r_checksum  <= '0;
        end else if (w_start_ok) begin
            r_base_word <= base_addr[31:2];
            r_count     <= count;
            r_issued    <= '0;
            r_received  <= '0;
            r_checksum  <= '0;
        end else begin
            if (w_req_hs) begin
                r_issued <= r_issued + 16'd1;
            end
            if (w_resp_hs) begin
                r_received <= r_received + 16'd1;
                r_checksum <= r_checksum + cacheresp_msg.data;
            end
        end
    end

`ifdef CACHE_SWEEP_RESPCHK_EN
    // Sticky flag for responses with the wrong type or out-of-order tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_resp_hs && ((cacheresp_msg.type_ != MEM_READ) ||
                                   (cacheresp_msg.opaque != r_received[7:0]))) begin
            r_err <= 1'b1;
        end
    end
`else
    assign r_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_sweep_reader.sv
// Self-checking bench for cache_sweep_reader: a behavioural cache model
// answers reads in order after a programmable delay, while the reference
// side predicts addresses, tags and the checksum from the sweep parameters.
module tb_cache_sweep_reader;
    import cache_sweep_reader_pkg::*;

    localparam int MAX_OUT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base_addr;
    logic [15:0]  count;
    logic         cachereq_val;
    logic         cachereq_rdy;
    mem_req_4B_t  cachereq_msg;
    logic         cacheresp_val;
    logic         cacheresp_rdy;
    mem_resp_4B_t cacheresp_msg;
    logic         busy;
    logic         done;
    logic [31:0]  checksum;
    logic         err;

    cache_sweep_reader #(.MAX_OUT(MAX_OUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .cachereq_val  (cachereq_val),
        .cachereq_rdy  (cachereq_rdy),
        .cachereq_msg  (cachereq_msg),
        .cacheresp_val (cacheresp_val),
        .cacheresp_rdy (cacheresp_rdy),
        .cacheresp_msg (cacheresp_msg),
        .busy          (busy),
        .done          (done),
        .checksum      (checksum),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  opaque;
        logic [31:0] data;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] data_q[$];
    logic [31:0] addr_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          req_n = 0;
    int          resp_n = 0;
    int          done_cnt = 0;
    int          max_out_seen = 0;
    int          stall_n = 0;
    int          outstanding;
    int          last_due = 0;
    int          rdy_mode = 2;
    int          dly_min = 1;
    int          dly_max = 1;
    bit          flush = 1'b0;
    bit          corrupt_next = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] exp_base = '0;
    logic [31:0] m_checksum = '0;
    mem_req_4B_t prev_msg;
    mem_req_4B_t exp_msg;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cache model and cycle monitor: drive at negedge, observe 1ns later.
    initial begin : cache_model
        pend_t       e;
        cachereq_rdy  = 1'b0;
        cacheresp_val = 1'b0;
        cacheresp_msg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (flush) pend_q.delete();
            case (rdy_mode)
                0:       cachereq_rdy = ($urandom_range(0, 3) != 0);
                1:       cachereq_rdy = 1'b0;
                default: cachereq_rdy = 1'b1;
            endcase
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                cacheresp_val = 1'b1;
                cacheresp_msg = '{type_: MEM_READ, opaque: pend_q[0].opaque,
                                  test: 2'd0, len: 2'd0, data: pend_q[0].data};
            end else begin
                cacheresp_val = 1'b0;
                cacheresp_msg = '0;
            end
            #1;
            chk("resp_rdy_vs_state", cacheresp_rdy, busy && !done);
            outstanding = req_n - resp_n;
            if (outstanding > max_out_seen) max_out_seen = outstanding;
            chk("outstanding_limit", outstanding <= MAX_OUT, 1);
            if (outstanding >= MAX_OUT) chk("val_low_at_limit", cachereq_val, 0);
            if (prev_stall && cachereq_val) chk("msg_stable", cachereq_msg, prev_msg);
            prev_stall = cachereq_val && !cachereq_rdy;
            if (prev_stall) stall_n++;
            prev_msg = cachereq_msg;
            if (cachereq_val && cachereq_rdy) begin
                exp_msg = '{type_: MEM_READ, opaque: 8'(req_n),
                            addr: exp_base + 32'(4 * req_n), len: 2'd0, data: 32'd0};
                chk("req_msg", cachereq_msg, exp_msg);
                addr_q.push_back(cachereq_msg.addr);
                if (data_q.size() > 0) e.data = data_q.pop_front();
                else e.data = $urandom();
                e.opaque = 8'(req_n);
                if (corrupt_next) begin
                    e.opaque = 8'd5;
                    corrupt_next = 1'b0;
                end
                e.due = cyc + $urandom_range(dly_min, dly_max);
                if (e.due < last_due) e.due = last_due;
                last_due = e.due;
                pend_q.push_back(e);
                req_n++;
            end
            if (cacheresp_val && cacheresp_rdy) begin
                m_checksum = m_checksum + pend_q[0].data;
                resp_n++;
                void'(pend_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic begin_sweep(input logic [31:0] base, input int n);
        @(negedge clk);
        exp_base     = {base[31:2], 2'b00};
        req_n        = 0;
        resp_n       = 0;
        m_checksum   = '0;
        done_cnt     = 0;
        max_out_seen = 0;
        stall_n      = 0;
        last_due     = 0;
        addr_q.delete();
        start     = 1'b1;
        base_addr = base;
        count     = 16'(n);
        @(negedge clk);
        start     = 1'b0;
        base_addr = $urandom();
        count     = 16'($urandom());
    endtask

    task automatic finish_sweep(input string tag, input int n, input logic exp_err);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            #2;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, done_cnt > 0, 1);
        repeat (3) @(negedge clk);
        #2;
        chk({tag, " done_once"}, done_cnt, 1);
        chk({tag, " reqs"}, req_n, n);
        chk({tag, " resps"}, resp_n, n);
        chk({tag, " checksum"}, checksum, m_checksum);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " err"}, err, exp_err);
    endtask

    task automatic run_sweep(input logic [31:0] base, input int n, input string tag);
        begin_sweep(base, n);
        finish_sweep(tag, n, 1'b0);
    endtask

    initial begin : stimulus
        logic exp_err_corrupt;
        rst       = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst req_val", cachereq_val, 0);
        chk("rst resp_rdy", cacheresp_rdy, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst checksum", checksum, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single word, response one cycle after the request.
        rdy_mode = 2; dly_min = 1; dly_max = 1;
        data_q.push_back(32'hDEADBEEF);
        begin_sweep(32'h100, 1);
        #2;
        chk("single first_cycle_req", addr_q.size(), 1);
        finish_sweep("single", 1, 1'b0);
        chk("single addr", addr_q[0], 32'h100);
        chk("single sum", checksum, 32'hDEADBEEF);

        // Backpressure on the first requests.
        rdy_mode = 1; dly_min = 1; dly_max = 2;
        fork
            run_sweep(32'h0, 4, "bp");
            begin
                repeat (5) @(negedge clk);
                rdy_mode = 2;
            end
        join
        chk("bp stalls", stall_n >= 3, 1);
        for (int i = 0; i < 4; i++) chk("bp addr", addr_q[i], 32'(4 * i));

        // Outstanding limit with slow responses.
        rdy_mode = 2; dly_min = 10; dly_max = 10;
        run_sweep($urandom(), 5, "limit");
        chk("limit reached", max_out_seen, MAX_OUT);

        // Zero-length sweep.
        @(negedge clk);
        req_n = 0; done_cnt = 0;
        start = 1'b1; count = 16'd0; base_addr = $urandom();
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("zero done", done, 1);
        chk("zero no_req", cachereq_val, 0);
        chk("zero busy", busy, 1);
        @(negedge clk);
        #2;
        chk("zero done_low", done, 0);
        chk("zero idle", busy, 0);
        chk("zero done_cnt", done_cnt, 1);
        chk("zero reqs", req_n, 0);

        // Address wrap at the top of memory.
        dly_min = 1; dly_max = 3;
        run_sweep(32'hFFFFFFFC, 2, "awrap");
        chk("awrap addr0", addr_q[0], 32'hFFFFFFFC);
        chk("awrap addr1", addr_q[1], 32'h0);

        // Checksum wrap-around.
        data_q.push_back(32'hFFFFFFFF);
        data_q.push_back(32'h00000002);
        run_sweep($urandom(), 2, "cwrap");
        chk("cwrap sum", checksum, 32'h1);

        // Bad response tag: err only exists with the checker built in.
`ifdef CACHE_SWEEP_RESPCHK_EN
        exp_err_corrupt = 1'b1;
`else
        exp_err_corrupt = 1'b0;
`endif
        corrupt_next = 1'b1;
        begin_sweep($urandom(), 3);
        finish_sweep("corrupt", 3, exp_err_corrupt);
        repeat (4) @(negedge clk);
        #2;
        chk("corrupt err_held", err, exp_err_corrupt);
        run_sweep($urandom(), 2, "err_clear");

        // Randomized sweeps.
        for (int s = 0; s < 10; s++) begin
            rdy_mode = 0;
            dly_min  = 1;
            dly_max  = $urandom_range(1, 8);
            run_sweep($urandom(), $urandom_range(1, 40), "rand");
        end

        // Reset in the middle of a sweep.
        rdy_mode = 2; dly_min = 3; dly_max = 3;
        begin_sweep($urandom(), 12);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst req_val", cachereq_val, 0);
        chk("midrst resp_rdy", cacheresp_rdy, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst err", err, 0);
        chk("midrst checksum", checksum, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("postrst pending", cacheresp_val, 1);
            chk("postrst resp_rdy", cacheresp_rdy, 0);
            chk("postrst checksum", checksum, 0);
            chk("postrst busy", busy, 0);
        end
        flush = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        run_sweep($urandom(), 6, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
